// File: rtl/pipe_pkg.sv
// pipe_pkg: shared forwarding-select codes, ALU opcodes and register constants for the pipeline.
package pipe_pkg;
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_ALU = 2'b10;
    localparam logic [4:0] REG_X0  = 5'd0;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs and EX-side outputs of the ID/EX register.
// Counter outputs exist only when ID_EX_HAZARD_CNT_EN is defined.
interface id_ex_stage_if #(
    parameter int DATAWIDTH = 32,
    parameter int REGADDR   = 5,
    parameter int ALUOPW    = 4
);
    logic                 flush_i, id_valid_i;
    logic [DATAWIDTH-1:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [REGADDR-1:0]   id_rs1_i, id_rs2_i, id_rd_i;
    logic                 id_reg_write_i, id_mem_read_i, id_mem_write_i, id_bsel_i;
    logic [ALUOPW-1:0]    id_alu_op_i;
    logic [REGADDR-1:0]   exmem_rd_i;
    logic                 exmem_reg_write_i;
    logic                 stall_o, ex_valid_o;
    logic [DATAWIDTH-1:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [REGADDR-1:0]   ex_rd_o;
    logic                 ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_bsel_o;
    logic [ALUOPW-1:0]    ex_alu_op_o;
    logic [1:0]           ex_fwd_a_o, ex_fwd_b_o;
`ifdef ID_EX_HAZARD_CNT_EN
    logic [31:0]          stall_cnt_o, flush_cnt_o;
`endif
    modport master (
        output flush_i, id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
               id_rs1_i, id_rs2_i, id_rd_i, id_reg_write_i, id_mem_read_i, id_mem_write_i,
               id_bsel_i, id_alu_op_i, exmem_rd_i, exmem_reg_write_i,
        input  stall_o, ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rd_o,
               ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_bsel_o, ex_alu_op_o,
`ifdef ID_EX_HAZARD_CNT_EN
               stall_cnt_o, flush_cnt_o,
`endif
               ex_fwd_a_o, ex_fwd_b_o
    );
    modport slave (
        input  flush_i, id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
               id_rs1_i, id_rs2_i, id_rd_i, id_reg_write_i, id_mem_read_i, id_mem_write_i,
               id_bsel_i, id_alu_op_i, exmem_rd_i, exmem_reg_write_i,
        output stall_o, ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rd_o,
               ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_bsel_o, ex_alu_op_o,
`ifdef ID_EX_HAZARD_CNT_EN
               stall_cnt_o, flush_cnt_o,
`endif
               ex_fwd_a_o, ex_fwd_b_o
    );
endinterface

// File: rtl/fwd_sel_calc.sv
// fwd_sel_calc: forwarding select for one source register; the nearer producer (EX) beats EX/MEM, x0 never forwards.
module fwd_sel_calc import pipe_pkg::*; #(
    parameter int REGADDR = 5
) (
    input  logic [REGADDR-1:0] rs,
    input  logic               ex_valid,
    input  logic               ex_reg_write,
    input  logic [REGADDR-1:0] ex_rd,
    input  logic               exmem_reg_write,
    input  logic [REGADDR-1:0] exmem_rd,
    output logic [1:0]         sel
);
    always_comb
        sel = (ex_valid && ex_reg_write && ex_rd != REGADDR'(REG_X0) && ex_rd == rs) ? FWD_ALU :
              (exmem_reg_write && exmem_rd != REGADDR'(REG_X0) && exmem_rd == rs) ? FWD_WB : FWD_REG;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, branch flush and precomputed forwarding selects.
// Optional hazard counters are enabled by defining ID_EX_HAZARD_CNT_EN.
module id_ex_stage import pipe_pkg::*; #(
    parameter int DATAWIDTH = 32,
    parameter int REGADDR   = 5,
    parameter int ALUOPW    = 4
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    logic       hazard, bubble;
    logic [1:0] fwd_a, fwd_b;
    assign hazard = bus.ex_valid_o && bus.ex_mem_read_o && bus.id_valid_i &&
                    bus.ex_rd_o != REGADDR'(REG_X0) &&
                    (bus.ex_rd_o == bus.id_rs1_i || bus.ex_rd_o == bus.id_rs2_i);
    assign bubble = bus.flush_i || hazard;
    assign bus.stall_o = hazard && !bus.flush_i;
    fwd_sel_calc #(.REGADDR(REGADDR)) u_fwd_a (
        .rs(bus.id_rs1_i), .ex_valid(bus.ex_valid_o), .ex_reg_write(bus.ex_reg_write_o),
        .ex_rd(bus.ex_rd_o), .exmem_reg_write(bus.exmem_reg_write_i), .exmem_rd(bus.exmem_rd_i),
        .sel(fwd_a)
    );
    fwd_sel_calc #(.REGADDR(REGADDR)) u_fwd_b (
        .rs(bus.id_rs2_i), .ex_valid(bus.ex_valid_o), .ex_reg_write(bus.ex_reg_write_o),
        .ex_rd(bus.ex_rd_o), .exmem_reg_write(bus.exmem_reg_write_i), .exmem_rd(bus.exmem_rd_i),
        .sel(fwd_b)
    );
    // A bubble is indistinguishable from the reset state, so both share one branch.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            bus.ex_valid_o     <= 1'b0;
            bus.ex_pc_o        <= {DATAWIDTH{1'b0}};
            bus.ex_rs1_data_o  <= {DATAWIDTH{1'b0}};
            bus.ex_rs2_data_o  <= {DATAWIDTH{1'b0}};
            bus.ex_imm_o       <= {DATAWIDTH{1'b0}};
            bus.ex_rd_o        <= {REGADDR{1'b0}};
            bus.ex_reg_write_o <= 1'b0;
            bus.ex_mem_read_o  <= 1'b0;
            bus.ex_mem_write_o <= 1'b0;
            bus.ex_bsel_o      <= 1'b0;
            bus.ex_alu_op_o    <= {ALUOPW{1'b0}};
            bus.ex_fwd_a_o     <= FWD_REG;
            bus.ex_fwd_b_o     <= FWD_REG;
        end else begin
            bus.ex_valid_o     <= bus.id_valid_i;
            bus.ex_pc_o        <= bus.id_pc_i;
            bus.ex_rs1_data_o  <= bus.id_rs1_data_i;
            bus.ex_rs2_data_o  <= bus.id_rs2_data_i;
            bus.ex_imm_o       <= bus.id_imm_i;
            bus.ex_rd_o        <= bus.id_rd_i;
            bus.ex_reg_write_o <= bus.id_reg_write_i;
            bus.ex_mem_read_o  <= bus.id_mem_read_i;
            bus.ex_mem_write_o <= bus.id_mem_write_i;
            bus.ex_bsel_o      <= bus.id_bsel_i;
            bus.ex_alu_op_o    <= bus.id_alu_op_i;
            bus.ex_fwd_a_o     <= fwd_a;
            bus.ex_fwd_b_o     <= fwd_b;
        end
    end
`ifdef ID_EX_HAZARD_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.stall_cnt_o <= 32'd0;
            bus.flush_cnt_o <= 32'd0;
        end else begin
            if (bus.stall_o && !(&bus.stall_cnt_o)) bus.stall_cnt_o <= bus.stall_cnt_o + 32'd1;
            if (bus.flush_i && !(&bus.flush_cnt_o)) bus.flush_cnt_o <= bus.flush_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven directed bench for id_ex_stage, plus reset sequences.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    id_ex_stage_if #(.DATAWIDTH(32), .REGADDR(5), .ALUOPW(4)) bus ();
    id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic       flush, valid;
        logic [4:0] rs1, rs2, rd;
        logic       rw, mr;
        logic [4:0] xm_rd;
        logic       xm_rw;
        logic       e_stall, e_bub;
        logic [1:0] e_fa, e_fb;
    } vec_t;
    vec_t vecs[18];
    function automatic vec_t mk(input logic flush, valid, input logic [4:0] rs1, rs2, rd,
                                input logic rw, mr, input logic [4:0] xm_rd, input logic xm_rw,
                                input logic e_stall, e_bub, input logic [1:0] e_fa, e_fb);
        vec_t v;
        v.flush = flush; v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.rw = rw; v.mr = mr; v.xm_rd = xm_rd; v.xm_rw = xm_rw;
        v.e_stall = e_stall; v.e_bub = e_bub; v.e_fa = e_fa; v.e_fb = e_fb;
        return v;
    endfunction
    function automatic logic [127:0] exp_data(input logic [31:0] pc);
        return {pc, 32'(pc * 3), ~pc, {pc[15:0], pc[31:16]}};
    endfunction
    task automatic drive(input vec_t v, input logic [31:0] pc);
        bus.flush_i = v.flush; bus.id_valid_i = v.valid; bus.id_pc_i = pc;
        bus.id_rs1_data_i = 32'(pc * 3); bus.id_rs2_data_i = ~pc; bus.id_imm_i = {pc[15:0], pc[31:16]};
        bus.id_rs1_i = v.rs1; bus.id_rs2_i = v.rs2; bus.id_rd_i = v.rd;
        bus.id_reg_write_i = v.rw; bus.id_mem_read_i = v.mr;
        bus.id_mem_write_i = pc[0]; bus.id_bsel_i = pc[1]; bus.id_alu_op_i = pc[5:2];
        bus.exmem_rd_i = v.xm_rd; bus.exmem_reg_write_i = v.xm_rw;
    endtask
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 128'(bus.ex_valid_o), 128'd0);
        check({tag, "_data"}, {bus.ex_pc_o, bus.ex_rs1_data_o, bus.ex_rs2_data_o, bus.ex_imm_o}, 128'd0);
        check({tag, "_ctrl"}, 128'({bus.ex_rd_o, bus.ex_reg_write_o, bus.ex_mem_read_o, bus.ex_mem_write_o,
                                    bus.ex_bsel_o, bus.ex_alu_op_o}), 128'd0);
        check({tag, "_fwd"}, 128'({bus.ex_fwd_a_o, bus.ex_fwd_b_o}), 128'd0);
        check({tag, "_stall"}, 128'(bus.stall_o), 128'd0);
`ifdef ID_EX_HAZARD_CNT_EN
        check({tag, "_cnt"}, {64'd0, bus.stall_cnt_o, bus.flush_cnt_o}, 128'd0);
`endif
    endtask
    initial begin
        int exp_sc = 0;
        int exp_fc = 0;
        logic [31:0] pc;
        vecs[0]  = mk(0,1, 1,2, 5,1,0,  0,0, 0,0, 2'b00,2'b00);
        vecs[1]  = mk(0,1, 5,6, 8,1,0,  0,0, 0,0, 2'b10,2'b00);
        vecs[2]  = mk(0,1, 1,2, 7,1,0,  5,1, 0,0, 2'b00,2'b00);
        vecs[3]  = mk(0,0, 0,0, 0,0,0,  8,1, 0,0, 2'b00,2'b00);
        vecs[4]  = mk(0,1, 3,7, 9,1,0,  7,1, 0,0, 2'b00,2'b01);
        vecs[5]  = mk(0,1, 1,2, 7,1,0,  0,0, 0,0, 2'b00,2'b00);
        vecs[6]  = mk(0,1, 1,2, 7,1,0,  9,1, 0,0, 2'b00,2'b00);
        vecs[7]  = mk(0,1, 7,4,10,1,0,  7,1, 0,0, 2'b10,2'b00);
        vecs[8]  = mk(0,1, 2,0, 3,1,1,  7,1, 0,0, 2'b00,2'b00);
        vecs[9]  = mk(0,1, 1,3,11,1,0, 10,1, 1,1, 2'b00,2'b00);
        vecs[10] = mk(0,1, 1,3,11,1,0,  3,1, 0,0, 2'b00,2'b01);
        vecs[11] = mk(0,1, 1,2, 0,1,0,  0,0, 0,0, 2'b00,2'b00);
        vecs[12] = mk(0,1, 0,0,12,1,0, 11,1, 0,0, 2'b00,2'b00);
        vecs[13] = mk(0,1, 1,1, 0,1,1,  0,1, 0,0, 2'b00,2'b00);
        vecs[14] = mk(0,1, 0,5,13,1,0, 12,1, 0,0, 2'b00,2'b00);
        vecs[15] = mk(0,1, 0,2, 4,1,1,  0,1, 0,0, 2'b00,2'b00);
        vecs[16] = mk(1,1, 4,0,15,1,0, 13,1, 0,1, 2'b00,2'b00);
        vecs[17] = mk(0,1, 4,0,14,1,0,  4,1, 0,0, 2'b01,2'b00);
        drive(mk(0,1, 3,3, 9,1,1, 9,1, 0,0, 2'b00,2'b00), 32'hDEAD_BEEF);
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            pc = 32'h0000_1000 + 32'(i * 7);
            drive(vecs[i], pc);
            #1;
            check($sformatf("v%0d_stall", i), 128'(bus.stall_o), 128'(vecs[i].e_stall));
            exp_sc += int'(vecs[i].e_stall);
            exp_fc += int'(vecs[i].flush);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), 128'(bus.ex_valid_o), 128'(vecs[i].e_bub ? 1'b0 : vecs[i].valid));
            check($sformatf("v%0d_fwd_a", i), 128'(bus.ex_fwd_a_o), 128'(vecs[i].e_fa));
            check($sformatf("v%0d_fwd_b", i), 128'(bus.ex_fwd_b_o), 128'(vecs[i].e_fb));
            check($sformatf("v%0d_rd", i), 128'(bus.ex_rd_o), 128'(vecs[i].e_bub ? 5'd0 : vecs[i].rd));
            check($sformatf("v%0d_ctrl", i),
                  128'({bus.ex_reg_write_o, bus.ex_mem_read_o, bus.ex_mem_write_o, bus.ex_bsel_o, bus.ex_alu_op_o}),
                  vecs[i].e_bub ? 128'd0 : 128'({vecs[i].rw, vecs[i].mr, pc[0], pc[1], pc[5:2]}));
            check($sformatf("v%0d_data", i), {bus.ex_pc_o, bus.ex_rs1_data_o, bus.ex_rs2_data_o, bus.ex_imm_o},
                  vecs[i].e_bub ? 128'd0 : exp_data(pc));
`ifdef ID_EX_HAZARD_CNT_EN
            check($sformatf("v%0d_cnt", i), {64'd0, bus.stall_cnt_o, bus.flush_cnt_o},
                  {64'd0, 32'(exp_sc), 32'(exp_fc)});
`endif
        end
        drive(mk(0,1, 1,2, 6,1,1, 14,1, 0,0, 2'b00,2'b00), 32'h0000_2000);
        #1;
        check("midrst_pre_stall", 128'(bus.stall_o), 128'd0);
        @(posedge clk);
        #1;
        check("midrst_load", 128'({bus.ex_valid_o, bus.ex_rd_o, bus.ex_mem_read_o}), 128'({1'b1, 5'd6, 1'b1}));
        drive(mk(0,1, 6,0, 7,1,0, 6,1, 0,0, 2'b00,2'b00), 32'h0000_2004);
        rst = 1'b1;
        #1;
        check("midrst_hazard_stall", 128'(bus.stall_o), 128'd1);
        @(posedge clk);
        #1;
        check_zero("midrst");
        rst = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
